// File: rtl/decoder_pkg.sv
// Shared decode/execute types: execute op codes, the decoded bundle handed to EX,
// the ID/EX pipeline register layout and the divider FSM states.
package decoder_pkg;

    typedef enum logic [3:0] {
        ADD, SUB, AND, OR, XOR, SHL, SHR, SAR, PASS2, MUL, MULH, DIV, DIVU, REM, REMU
    } ex_op_t;

    typedef struct packed {
        ex_op_t     exop;
        logic [4:0] rd;
        logic       wb_en;
    } decoded_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        ex_op_t      exop;
        logic [4:0]  rd;
        logic        wb_en;
        logic [31:0] op1;
        logic [31:0] op2;
        logic        cond_true;
    } idex_t;

    typedef enum logic [1:0] {IDLE, RUN, DONE} div_state_t;

    function automatic logic is_div(ex_op_t op);
        return op inside {DIV, DIVU, REM, REMU};
    endfunction

endpackage

// File: rtl/id_out_if.sv
// Decode-stage output bundle; decode drives it through `self`, execute reads it through `other`.
interface id_out_if;
    import decoder_pkg::*;

    logic [31:0] pc;
    logic [31:0] nextpc;
    decoded_t    dec;
    logic [31:0] op1;
    logic [31:0] op2;
    logic        cond_true;
    logic        branch;
    logic [31:0] branch_dest;
    logic        bubble;
    logic        stall;

    modport self  (output pc, nextpc, dec, op1, op2, cond_true, branch, branch_dest, bubble, stall);
    modport other (input  pc, nextpc, dec, op1, op2, cond_true, branch, branch_dest, bubble, stall);
endinterface

// File: rtl/ex_divider.sv
// Iterative restoring divider on operand magnitudes, DIV_BITS_PER_CYCLE quotient bits
// per RUN cycle; divide-by-zero and signed overflow skip RUN and go straight to DONE.
module ex_divider
    import decoder_pkg::*;
#(
    parameter int DIV_BITS_PER_CYCLE = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        abort,
    input  logic        signed_op,
    input  logic        want_rem,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] result
);
    localparam int ITERS = 32 / DIV_BITS_PER_CYCLE;

    div_state_t  state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [31:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
    logic        qneg_q, qneg_d, rneg_q, rneg_d, wrem_q, wrem_d;
    logic [31:0] a_mag, b_mag, r, q;
    logic [32:0] sh, diff;

    always_comb begin
        a_mag = (signed_op & a[31]) ? -a : a;
        b_mag = (signed_op & b[31]) ? -b : b;

        // quo_q doubles as the dividend shift register while quotient bits fill in from the right
        r    = rem_q;
        q    = quo_q;
        sh   = '0;
        diff = '0;
        for (int k = 0; k < DIV_BITS_PER_CYCLE; k++) begin
            sh   = {r, q[31]};
            diff = sh - {1'b0, dvs_q};
            q    = {q[30:0], ~diff[32]};
            r    = diff[32] ? sh[31:0] : diff[31:0];
        end

        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvs_d   = dvs_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        wrem_d  = wrem_q;
        case (state_q)
            IDLE: if (start && !abort) begin
                dvs_d   = b_mag;
                wrem_d  = want_rem;
                cnt_d   = 6'(ITERS);
                rem_d   = '0;
                quo_d   = a_mag;
                qneg_d  = signed_op & (a[31] ^ b[31]);
                rneg_d  = signed_op & a[31];
                state_d = RUN;
                if (b == 32'd0) begin
                    quo_d   = '1;
                    rem_d   = a;
                    qneg_d  = 1'b0;
                    rneg_d  = 1'b0;
                    state_d = DONE;
                end else if (signed_op && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    quo_d   = 32'h8000_0000;
                    rem_d   = '0;
                    qneg_d  = 1'b0;
                    rneg_d  = 1'b0;
                    state_d = DONE;
                end
            end
            RUN: begin
                rem_d = r;
                quo_d = q;
                cnt_d = cnt_q - 6'd1;
                if (cnt_q == 6'd1) state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
        if (abort) state_d = IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            wrem_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dvs_q   <= dvs_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            wrem_q  <= wrem_d;
        end
    end

    assign busy   = !abort && ((state_q == RUN) || (state_q == IDLE && start));
    assign done   = (state_q == DONE);
    assign result = wrem_q ? (rneg_q ? -rem_q : rem_q) : (qneg_q ? -quo_q : quo_q);

endmodule

// File: rtl/ex_stage.sv
// Execute stage: ID/EX register, single-cycle ALU/multiplier, iterative divider and the
// registered result bundle toward memory/writeback.
module ex_stage
    import decoder_pkg::*;
#(
    parameter int DIV_BITS_PER_CYCLE = 1
) (
    input  logic           clk,
    input  logic           rst,
    id_out_if.other        id,
    input  logic           flush,
    output logic           ex_busy,
    output logic           out_valid,
    output logic [31:0]    out_pc,
    output logic [31:0]    out_result,
    output logic [4:0]     out_rd,
    output logic           out_wb_en
);
    idex_t       r_q, r_d;
    logic [63:0] prod;
    logic [31:0] alu_res, div_res;
    logic        div_start, div_busy, div_done;
    logic        out_valid_q, out_valid_d, out_wb_en_q, out_wb_en_d;
    logic [31:0] out_pc_q, out_pc_d, out_result_q, out_result_d;
    logic [4:0]  out_rd_q, out_rd_d;

    assign div_start = r_q.valid & is_div(r_q.exop) & r_q.cond_true;
    assign ex_busy   = div_busy;

    ex_divider #(.DIV_BITS_PER_CYCLE(DIV_BITS_PER_CYCLE)) u_div (
        .clk       (clk),
        .rst       (rst),
        .start     (div_start),
        .abort     (flush),
        .signed_op (r_q.exop inside {DIV, REM}),
        .want_rem  (r_q.exop inside {REM, REMU}),
        .a         (r_q.op1),
        .b         (r_q.op2),
        .busy      (div_busy),
        .done      (div_done),
        .result    (div_res)
    );

    always_comb begin
        // sign-extended 64x64 product: low word serves MUL, high word is the signed MULH
        prod = {{32{r_q.op1[31]}}, r_q.op1} * {{32{r_q.op2[31]}}, r_q.op2};
        case (r_q.exop)
            ADD:     alu_res = r_q.op1 + r_q.op2;
            SUB:     alu_res = r_q.op1 - r_q.op2;
            AND:     alu_res = r_q.op1 & r_q.op2;
            OR:      alu_res = r_q.op1 | r_q.op2;
            XOR:     alu_res = r_q.op1 ^ r_q.op2;
            SHL:     alu_res = r_q.op1 << r_q.op2[4:0];
            SHR:     alu_res = r_q.op1 >> r_q.op2[4:0];
            SAR:     alu_res = $signed(r_q.op1) >>> r_q.op2[4:0];
            PASS2:   alu_res = r_q.op2;
            MUL:     alu_res = prod[31:0];
            MULH:    alu_res = prod[63:32];
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        r_d = r_q;
        if (flush) begin
            r_d.valid = 1'b0;
        end else if (!ex_busy) begin
            r_d.valid     = !(id.bubble | id.stall);
            r_d.pc        = id.pc;
            r_d.exop      = id.dec.exop;
            r_d.rd        = id.dec.rd;
            r_d.wb_en     = id.dec.wb_en;
            r_d.op1       = id.op1;
            r_d.op2       = id.op2;
            r_d.cond_true = id.cond_true;
        end

        out_valid_d  = 1'b0;
        out_wb_en_d  = 1'b0;
        out_pc_d     = out_pc_q;
        out_result_d = out_result_q;
        out_rd_d     = out_rd_q;
        if (!flush && ((r_q.valid && !div_start) || div_done)) begin
            out_valid_d  = 1'b1;
            out_wb_en_d  = r_q.wb_en & r_q.cond_true;
            out_pc_d     = r_q.pc;
            out_result_d = div_done ? div_res : alu_res;
            out_rd_d     = r_q.rd;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q          <= '0;
            out_valid_q  <= 1'b0;
            out_wb_en_q  <= 1'b0;
            out_pc_q     <= '0;
            out_result_q <= '0;
            out_rd_q     <= '0;
        end else begin
            r_q          <= r_d;
            out_valid_q  <= out_valid_d;
            out_wb_en_q  <= out_wb_en_d;
            out_pc_q     <= out_pc_d;
            out_result_q <= out_result_d;
            out_rd_q     <= out_rd_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_wb_en  = out_wb_en_q;
    assign out_pc     = out_pc_q;
    assign out_result = out_result_q;
    assign out_rd     = out_rd_q;

endmodule

// File: tb/tb_ex_stage.sv
// Directed plus random bench for ex_stage against an arithmetic reference model.
module tb_ex_stage;
    import decoder_pkg::*;

    logic        clk = 1'b0;
    logic        rst, flush;
    logic        ex_busy, out_valid, out_wb_en;
    logic [31:0] out_pc, out_result;
    logic [4:0]  out_rd;
    logic [31:0] pc_ctr = 32'h100;
    int          total = 0;
    int          bad   = 0;

    always #5 clk = ~clk;

    id_out_if idif ();

    ex_stage dut (
        .clk        (clk),
        .rst        (rst),
        .id         (idif),
        .flush      (flush),
        .ex_busy    (ex_busy),
        .out_valid  (out_valid),
        .out_pc     (out_pc),
        .out_result (out_result),
        .out_rd     (out_rd),
        .out_wb_en  (out_wb_en)
    );

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model(ex_op_t op, logic [31:0] a, logic [31:0] b);
        longint      sa, sb;
        logic [63:0] ua, ub, tmp;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (op)
            ADD:   return a + b;
            SUB:   return a - b;
            AND:   return a & b;
            OR:    return a | b;
            XOR:   return a ^ b;
            SHL:   return a << b[4:0];
            SHR:   return a >> b[4:0];
            SAR:   begin tmp = sa >>> b[4:0]; return tmp[31:0]; end
            PASS2: return b;
            MUL:   begin tmp = ua * ub; return tmp[31:0]; end
            MULH:  begin tmp = sa * sb; return tmp[63:32]; end
            DIV:   begin if (b == 0) return 32'hFFFF_FFFF; tmp = sa / sb; return tmp[31:0]; end
            DIVU:  begin if (b == 0) return 32'hFFFF_FFFF; return a / b; end
            REM:   begin if (b == 0) return a; tmp = sa % sb; return tmp[31:0]; end
            REMU:  begin if (b == 0) return a; return a % b; end
            default: return 32'd0;
        endcase
    endfunction

    function automatic int model_lat(ex_op_t op, logic [31:0] a, logic [31:0] b, logic cond);
        if (!cond || !(op inside {DIV, DIVU, REM, REMU})) return 1;
        if (b == 0 || (op inside {DIV, REM} && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) return 2;
        return 34;
    endfunction

    task automatic drive(ex_op_t op, logic [31:0] a, logic [31:0] b, logic [4:0] rd, logic wb, logic cond);
        pc_ctr           = pc_ctr + 32'd4;
        idif.pc          = pc_ctr;
        idif.nextpc      = pc_ctr + 32'd4;
        idif.dec.exop    = op;
        idif.dec.rd      = rd;
        idif.dec.wb_en   = wb;
        idif.op1         = a;
        idif.op2         = b;
        idif.cond_true   = cond;
        idif.bubble      = 1'b0;
        idif.stall       = 1'b0;
    endtask

    // Issue one instruction; decode holds it while ex_busy, then advances to a bubble.
    task automatic run_op(string tag, ex_op_t op, logic [31:0] a, logic [31:0] b,
                          logic [4:0] rd, logic wb, logic cond);
        int          lat, busy_n, exp_lat;
        logic [31:0] exp, ipc;
        exp     = model(op, a, b);
        exp_lat = model_lat(op, a, b, cond);
        drive(op, a, b, rd, wb, cond);
        ipc = pc_ctr;
        @(posedge clk); #1;
        lat    = 0;
        busy_n = 0;
        while (1) begin
            if (ex_busy) begin
                busy_n++;
                idif.stall = 1'($urandom_range(0, 1));
            end else begin
                idif.stall  = 1'b0;
                idif.bubble = 1'b1;
            end
            @(posedge clk); #1;
            lat++;
            if (out_valid || lat > 60) break;
        end
        chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        chk({tag, "_busy"}, 32'(busy_n), 32'(exp_lat - 1));
        if (cond) chk({tag, "_res"}, out_result, exp);
        chk({tag, "_rd"}, {27'd0, out_rd}, {27'd0, rd});
        chk({tag, "_wb"}, {31'd0, out_wb_en}, {31'd0, wb & cond});
        chk({tag, "_pc"}, out_pc, ipc);
        idif.bubble = 1'b1;
        @(posedge clk); #1;
        chk({tag, "_bubble"}, {31'd0, out_valid}, 32'd0);
    endtask

    initial begin
        int          stray;
        ex_op_t      rop;
        logic [31:0] ra, rb;
        rst   = 1'b1;
        flush = 1'b0;
        drive(ADD, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0);
        idif.bubble = 1'b1;
        idif.branch = 1'b0;
        idif.branch_dest = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_wb", {31'd0, out_wb_en}, 32'd0);
        chk("rst_pc", out_pc, 32'd0);
        chk("rst_res", out_result, 32'd0);
        chk("rst_rd", {27'd0, out_rd}, 32'd0);
        chk("rst_busy", {31'd0, ex_busy}, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        run_op("add", ADD, 32'd5, 32'd7, 5'd3, 1'b1, 1'b1);
        run_op("mulh", MULH, 32'hFFFF_FFFF, 32'd2, 5'd4, 1'b1, 1'b1);
        run_op("mul", MUL, 32'hFFFF_FFFF, 32'd2, 5'd5, 1'b1, 1'b1);
        run_op("div", DIV, -32'sd7, 32'd2, 5'd6, 1'b1, 1'b1);
        run_op("rem", REM, -32'sd7, 32'd2, 5'd7, 1'b1, 1'b1);
        run_op("divu0", DIVU, 32'd9, 32'd0, 5'd8, 1'b1, 1'b1);
        run_op("remu0", REMU, 32'd9, 32'd0, 5'd9, 1'b1, 1'b1);
        run_op("divovf", DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10, 1'b1, 1'b1);
        run_op("removf", REM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 1'b1, 1'b1);
        run_op("pred_div", DIV, 32'd50, 32'd3, 5'd12, 1'b1, 1'b0);
        run_op("sar", SAR, 32'h8000_00F0, 32'd36, 5'd13, 1'b1, 1'b1);

        // flush ten cycles into RUN
        drive(DIV, 32'd1000, 32'd7, 5'd14, 1'b1, 1'b1);
        @(posedge clk); #1;
        repeat (11) begin @(posedge clk); #1; end
        chk("flush_pre_busy", {31'd0, ex_busy}, 32'd1);
        flush = 1'b1;
        #1;
        chk("flush_busy_comb", {31'd0, ex_busy}, 32'd0);
        idif.bubble = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        chk("flush_busy", {31'd0, ex_busy}, 32'd0);
        chk("flush_valid", {31'd0, out_valid}, 32'd0);
        stray = 0;
        repeat (40) begin @(posedge clk); #1; if (out_valid || ex_busy) stray++; end
        chk("flush_quiet", 32'(stray), 32'd0);
        run_op("post_flush_add", ADD, 32'd3, 32'd4, 5'd15, 1'b1, 1'b1);

        // reset in the middle of RUN
        drive(DIVU, 32'd12345, 32'd11, 5'd16, 1'b1, 1'b1);
        repeat (6) begin @(posedge clk); #1; end
        rst = 1'b1;
        idif.bubble = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("mrst_valid", {31'd0, out_valid}, 32'd0);
        chk("mrst_pc", out_pc, 32'd0);
        chk("mrst_res", out_result, 32'd0);
        chk("mrst_rd", {27'd0, out_rd}, 32'd0);
        chk("mrst_wb", {31'd0, out_wb_en}, 32'd0);
        chk("mrst_busy", {31'd0, ex_busy}, 32'd0);
        stray = 0;
        repeat (40) begin @(posedge clk); #1; if (out_valid || ex_busy) stray++; end
        chk("mrst_quiet", 32'(stray), 32'd0);

        for (int n = 0; n < 40; n++) begin
            rop = ex_op_t'($urandom_range(0, 14));
            ra  = $urandom;
            rb  = $urandom;
            case ($urandom_range(0, 3))
                0: begin ra = ra & 32'hFF; rb = (rb & 32'hF) + 32'd1; end
                1: rb = 32'd0;
                2: begin ra = -(ra & 32'hFFFF); rb = rb | 32'hFFFF_0000; end
                default: ;
            endcase
            run_op("rand", rop, ra, rb, 5'($urandom), 1'($urandom), ($urandom_range(0, 5) != 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
